// File: rtl/marquee_multi_mode_pkg.sv
// rtl/marquee_multi_mode_pkg.sv - mode encoding, widths and next-pattern function for the LED marquee
package marquee_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    localparam int PWM_W   = 4;
    localparam int MAX_LED = 32;

    typedef struct packed {
        logic [MAX_LED-1:0] pattern;
        logic               dir;
    } step_t;

    // Works on a zero-padded 32-bit pattern; msb is the index of the top LED in use.
    function automatic step_t next_pattern(input mode_t mode, input logic [MAX_LED-1:0] pattern,
                                           input logic dir, input logic [4:0] msb);
        logic [MAX_LED-1:0] mask;
        logic [MAX_LED-1:0] rol;
        logic [MAX_LED-1:0] ror;
        step_t              r;
        for (int i = 0; i < MAX_LED; i++) begin
            mask[i] = (i <= int'(msb));
        end
        rol      = {pattern[MAX_LED-2:0], 1'b0};
        rol[0]   = pattern[msb];
        ror      = {1'b0, pattern[MAX_LED-1:1]};
        ror[msb] = pattern[0];
        r.pattern = rol;
        r.dir     = dir;
        case (mode)
            MODE_ROT_L: begin
                r.pattern = rol;
                r.dir     = 1'b1;
            end
            MODE_ROT_R: begin
                r.pattern = ror;
                r.dir     = 1'b0;
            end
            MODE_BOUNCE: begin
                if (dir && pattern[msb]) begin
                    r.pattern = ror;
                    r.dir     = 1'b0;
                end else if (!dir && pattern[0]) begin
                    r.pattern = rol;
                    r.dir     = 1'b1;
                end else begin
                    r.pattern = dir ? rol : ror;
                end
            end
            MODE_FILL: begin
                r.pattern    = rol;
                r.pattern[0] = ~pattern[msb];
                r.dir        = 1'b1;
            end
        endcase
        r.pattern = r.pattern & mask;
        return r;
    endfunction

endpackage

// File: rtl/marquee_multi_mode_if.sv
// rtl/marquee_multi_mode_if.sv - control inputs and LED outputs of the marquee
interface marquee_multi_mode_if #(
    parameter int N_LED = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic [N_LED-1:0] led;
    logic             led4_g;
    logic             led5_g;

    modport master (output en, mode, speed, input led, led4_g, led5_g);
    modport slave  (input en, mode, speed, output led, led4_g, led5_g);
endinterface

// File: rtl/marquee_tick_gen.sv
// rtl/marquee_tick_gen.sv - prescaler plus 2^speed divider producing a one-cycle step pulse
module marquee_tick_gen #(
    parameter int DIV_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       step
);
    localparam int PRESC_W = $clog2(DIV_MAX);

    logic [PRESC_W-1:0] presc;
    logic [2:0]         step_cnt;
    logic [2:0]         step_lim;
    logic               base_tick;

    assign base_tick = en && (presc == PRESC_W'(DIV_MAX - 1));
    assign step_lim  = 3'((4'd1 << speed) - 4'd1);
    // >= rather than == so lowering speed mid-count fires on the next base tick.
    assign step      = base_tick && (step_cnt >= step_lim);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc    <= '0;
            step_cnt <= '0;
        end else if (en) begin
            if (base_tick) begin
                presc    <= '0;
                step_cnt <= step ? 3'd0 : step_cnt + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/marquee_multi_mode.sv
// rtl/marquee_multi_mode.sv - multi-mode LED marquee top; MARQUEE_PWM_DIM_EN adds PWM dimming of led
module marquee_multi_mode
    import marquee_pkg::*;
#(
    parameter int CLK_HZ   = 125000000,
    parameter int N_LED    = 4,
    parameter int DIV_MAX  = CLK_HZ / 4,
    parameter int DIM_DUTY = 4
) (
    input logic                 clk,
    input logic                 rst,
    marquee_multi_mode_if.slave bus
);
    mode_t              mode_in;
    mode_t              mode_q;
    logic [N_LED-1:0]   pat_q;
    logic               dir_q;
    logic               beat_q;
    logic               reload;
    logic               step;
    logic [MAX_LED-1:0] pat_ext;
    step_t              nxt;

    assign mode_in = mode_t'(bus.mode);
    assign reload  = (mode_in != mode_q);

    marquee_tick_gen #(.DIV_MAX(DIV_MAX)) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .clr   (reload),
        .speed (bus.speed),
        .step  (step)
    );

    always_comb begin
        pat_ext              = '0;
        pat_ext[N_LED-1:0]   = pat_q;
        nxt                  = next_pattern(mode_q, pat_ext, dir_q, 5'(N_LED - 1));
    end

    // Reload outranks a coincident step; step already implies en.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= mode_in;
            pat_q  <= N_LED'(1);
            dir_q  <= 1'b1;
            beat_q <= 1'b0;
        end else begin
            mode_q <= mode_in;
            if (reload) begin
                pat_q <= N_LED'(1);
                dir_q <= (mode_in != MODE_ROT_R);
            end else if (step) begin
                pat_q  <= nxt.pattern[N_LED-1:0];
                dir_q  <= nxt.dir;
                beat_q <= ~beat_q;
            end
        end
    end

    assign bus.led4_g = beat_q;
    assign bus.led5_g = dir_q;

`ifdef MARQUEE_PWM_DIM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign bus.led = ({1'b0, pwm_cnt} < (PWM_W + 1)'(DIM_DUTY)) ? pat_q : '0;
`else
    assign bus.led = pat_q;
`endif

endmodule

// File: tb/tb_marquee_multi_mode.sv
// tb/tb_marquee_multi_mode.sv - directed-vector bench for marquee_multi_mode with N_LED=4, DIV_MAX=4
module tb_marquee_multi_mode;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    marquee_multi_mode_if #(.N_LED(4)) bus ();

    marquee_multi_mode #(.N_LED(4), .DIV_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_beat    = 1'b0;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] want;
        rst = 1'b1; bus.en = 1'b1; bus.mode = 2'b00; bus.speed = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.led !== 4'b0001 || bus.led4_g !== 1'b0 || bus.led5_g !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_state cyc%0d: led=%b g4=%b g5=%b, want 0001/0/1", i, bus.led, bus.led4_g, bus.led5_g);
            end
        end
        rst = 1'b0;
        exp_beat = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            want = (k == 4) ? 4'b0010 : 4'b0001;
            if (k == 4) exp_beat = 1'b1;
            vectors++;
            if (bus.led !== want || bus.led4_g !== exp_beat) begin
                miscompares++;
                $display("FAIL first_step clk%0d: led=%b g4=%b, want %b/%b", k, bus.led, bus.led4_g, want, exp_beat);
            end
        end
    endtask

    task automatic test_rotate_left();
        logic [3:0] seq [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] prev = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            cycles(3);
            vectors++;
            if (bus.led !== prev) begin
                miscompares++;
                $display("FAIL rotl_hold%0d: led=%b, want %b", i, bus.led, prev);
            end
            cycles(1);
            exp_beat = ~exp_beat;
            vectors++;
            if (bus.led !== seq[i] || bus.led4_g !== exp_beat || bus.led5_g !== 1'b1) begin
                miscompares++;
                $display("FAIL rotl_step%0d: led=%b g4=%b g5=%b, want %b/%b/1", i, bus.led, bus.led4_g, bus.led5_g, seq[i], exp_beat);
            end
            prev = seq[i];
        end
        bus.speed = 2'd2;
        cycles(15);
        vectors++;
        if (bus.led !== 4'b0010) begin
            miscompares++;
            $display("FAIL speed2_hold: led=%b, want 0010", bus.led);
        end
        cycles(1);
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b0100 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL speed2_step: led=%b g4=%b, want 0100/%b", bus.led, bus.led4_g, exp_beat);
        end
        cycles(8);
        bus.speed = 2'd0;
        cycles(3);
        vectors++;
        if (bus.led !== 4'b0100) begin
            miscompares++;
            $display("FAIL speed_drop_hold: led=%b, want 0100", bus.led);
        end
        cycles(1);
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b1000 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL speed_drop_step: led=%b g4=%b, want 1000/%b", bus.led, bus.led4_g, exp_beat);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic       dirs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.mode = 2'b10;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b1 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL bounce_reload: led=%b g4=%b g5=%b, want 0001/%b/1", bus.led, bus.led4_g, bus.led5_g, exp_beat);
        end
        for (int i = 0; i < 7; i++) begin
            cycles(4);
            exp_beat = ~exp_beat;
            vectors++;
            if (bus.led !== seq[i] || bus.led5_g !== dirs[i] || bus.led4_g !== exp_beat) begin
                miscompares++;
                $display("FAIL bounce_step%0d: led=%b g5=%b g4=%b, want %b/%b/%b", i, bus.led, bus.led5_g, bus.led4_g, seq[i], dirs[i], exp_beat);
            end
        end
    endtask

    task automatic test_fill();
        logic [3:0] seq [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        bus.mode = 2'b11;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_reload: led=%b g5=%b, want 0001/1", bus.led, bus.led5_g);
        end
        for (int i = 0; i < 8; i++) begin
            cycles(4);
            exp_beat = ~exp_beat;
            vectors++;
            if (bus.led !== seq[i] || bus.led4_g !== exp_beat) begin
                miscompares++;
                $display("FAIL fill_step%0d: led=%b g4=%b, want %b/%b", i, bus.led, bus.led4_g, seq[i], exp_beat);
            end
        end
    endtask

    task automatic test_freeze();
        bus.mode = 2'b00;
        cycles(9);
        exp_beat = ~exp_beat;
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b0100 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL freeze_setup: led=%b g4=%b, want 0100/%b", bus.led, bus.led4_g, exp_beat);
        end
        cycles(2);
        bus.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            vectors++;
            if (bus.led !== 4'b0100 || bus.led4_g !== exp_beat) begin
                miscompares++;
                $display("FAIL freeze_hold%0d: led=%b g4=%b, want 0100/%b", i, bus.led, bus.led4_g, exp_beat);
            end
        end
        bus.en = 1'b1;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0100) begin
            miscompares++;
            $display("FAIL resume_hold: led=%b, want 0100", bus.led);
        end
        cycles(1);
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b1000 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL resume_step: led=%b g4=%b, want 1000/%b", bus.led, bus.led4_g, exp_beat);
        end
    endtask

    task automatic test_mode_switch();
        cycles(12);
        exp_beat = ~exp_beat;
        exp_beat = ~exp_beat;
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b0100) begin
            miscompares++;
            $display("FAIL switch_setup: led=%b, want 0100", bus.led);
        end
        bus.mode = 2'b01;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b0 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL switch_reload: led=%b g5=%b g4=%b, want 0001/0/%b", bus.led, bus.led5_g, bus.led4_g, exp_beat);
        end
        cycles(3);
        vectors++;
        if (bus.led !== 4'b0001) begin
            miscompares++;
            $display("FAIL rotr_hold: led=%b, want 0001", bus.led);
        end
        cycles(1);
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b1000 || bus.led5_g !== 1'b0 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL rotr_step: led=%b g5=%b g4=%b, want 1000/0/%b", bus.led, bus.led5_g, bus.led4_g, exp_beat);
        end
        cycles(3);
        bus.mode = 2'b00;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b1 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL reload_beats_step: led=%b g5=%b g4=%b, want 0001/1/%b", bus.led, bus.led5_g, bus.led4_g, exp_beat);
        end
        cycles(4);
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b0010 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL post_reload_step: led=%b g4=%b, want 0010/%b", bus.led, bus.led4_g, exp_beat);
        end
        bus.en = 1'b0;
        bus.mode = 2'b01;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b0 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL reload_while_off: led=%b g5=%b g4=%b, want 0001/0/%b", bus.led, bus.led5_g, bus.led4_g, exp_beat);
        end
        bus.en = 1'b1;
        cycles(4);
        exp_beat = ~exp_beat;
        vectors++;
        if (bus.led !== 4'b1000 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL resume_after_reload: led=%b g4=%b, want 1000/%b", bus.led, bus.led4_g, exp_beat);
        end
    endtask

    task automatic test_mid_reset();
        cycles(2);
        rst = 1'b1;
        bus.mode = 2'b10;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led4_g !== 1'b0 || bus.led5_g !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: led=%b g4=%b g5=%b, want 0001/0/1", bus.led, bus.led4_g, bus.led5_g);
        end
        rst = 1'b0;
        bus.mode = 2'b01;
        exp_beat = 1'b0;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_reload: led=%b g5=%b, want 0001/0", bus.led, bus.led5_g);
        end
        cycles(3);
        vectors++;
        if (bus.led !== 4'b0001) begin
            miscompares++;
            $display("FAIL post_reset_hold: led=%b, want 0001", bus.led);
        end
        cycles(1);
        exp_beat = 1'b1;
        vectors++;
        if (bus.led !== 4'b1000 || bus.led5_g !== 1'b0 || bus.led4_g !== exp_beat) begin
            miscompares++;
            $display("FAIL post_reset_step: led=%b g5=%b g4=%b, want 1000/0/1", bus.led, bus.led5_g, bus.led4_g);
        end
    endtask

    task automatic test_reset_captures_mode();
        rst = 1'b1;
        bus.mode = 2'b00;
        cycles(1);
        rst = 1'b0;
        cycles(1);
        vectors++;
        if (bus.led !== 4'b0001 || bus.led5_g !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mode_capture: led=%b g5=%b, want 0001/1", bus.led, bus.led5_g);
        end
        cycles(3);
        vectors++;
        if (bus.led !== 4'b0010 || bus.led4_g !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_capture_step: led=%b g4=%b, want 0010/1", bus.led, bus.led4_g);
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_bounce();
        test_fill();
        test_freeze();
        test_mode_switch();
        test_mid_reset();
        test_reset_captures_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/marquee_multi_mode.md
Name: marquee_multi_mode

Overview:
Parametrised successor to the 4-LED marquee for the 125 MHz board.
- Drives an N_LED-wide pattern with four run-time modes: rotate left, rotate right, bounce and Johnson fill/clear.
- Step rate is programmable.
- Provides heartbeat (led4_g) and direction (led5_g) indicators.
- Sits directly on the board LED pins; control inputs come from switches or buttons, already synchronised upstream.

Parameters:
- CLK_HZ, 125000000, input clock frequency (documentation and default derivation only).
- N_LED, 4, pattern width; legal range 2..32.
- DIV_MAX, 31250000, base-tick prescaler period in clocks (default = 4 base ticks/s at 125 MHz); must be >= 2; benches override it with a small value.
- DIM_DUTY, 4, PWM on-count out of 16; used only when MARQUEE_PWM_DIM_EN is defined.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes all counters and the pattern.
- mode  in  2  00 rotate left, 01 rotate right, 10 bounce, 11 fill.
- speed  in  2  one step every DIV_MAX * 2^speed clocks.
- led  out  N_LED  pattern output.
- led4_g  out  1  heartbeat; toggles on every step.
- led5_g  out  1  direction flag; 1 = moving toward MSB.

Behaviour:
Reset
- rst sampled high on a clk edge gives: led = 1 (LSB lit), led4_g = 0, led5_g = 1, prescaler = 0, step counter = 0, mode_q = mode.
- Reset mid-operation aborts everything in that same edge.

Tick generation
- Prescaler counts 0..DIV_MAX-1 while en = 1; wrap produces a 1-cycle base_tick.
- Step counter counts base_ticks. When base_tick arrives with step_cnt >= 2^speed - 1, a 1-cycle step pulse fires and step_cnt clears.
- The >= compare means a speed decrease mid-count fires on the next base_tick.

Step latency
- First step occurs DIV_MAX * 2^speed clocks after reset release.
- The pattern register updates on the edge where step = 1.

Pattern on each step
- Rotate left: led <= {led[N-2:0], led[N-1]}; dir = 1.
- Rotate right: led <= {led[0], led[N-1:1]}; dir = 0.
- Bounce:
  - if dir = 1 and led[N-1] = 1: dir <= 0 and shift right.
  - if dir = 0 and led[0] = 1: dir <= 1 and shift left.
  - otherwise shift in direction dir.
  - End LEDs are lit for one step each (no dwell).
- Fill: led <= {led[N-2:0], ~led[N-1]}; period 2*N_LED steps; dir = 1.
- led4_g toggles on every step; led5_g = dir at all times.

Mode change
- mode_q registers mode each cycle. If mode != mode_q, the next edge applies:
  - led = 1.
  - dir = 0 if the new mode is rotate right, else 1.
  - prescaler and step_cnt = 0.
  - led4_g unchanged.
- Reload has priority over a coincident step.

en behaviour
- en = 0 holds prescaler, step_cnt, led, dir and led4_g.
- Mode-change reload still applies while en = 0.
- Resume continues from the held counts.

Priority: rst > mode reload > step > hold.

Optional Feature:
MARQUEE_PWM_DIM_EN
- Defined:
  - A free-running 4-bit pwm_cnt is added (reset 0; runs regardless of en).
  - led = pattern when pwm_cnt < DIM_DUTY, else 0.
  - led4_g and led5_g are not dimmed.
  - The pattern register itself is unaffected.
- Undefined: led = pattern register directly, and the PWM counter is absent.

Decomposition:
- Package marquee_pkg:
  - mode_t enum (MODE_ROT_L = 2'b00, MODE_ROT_R = 2'b01, MODE_BOUNCE = 2'b10, MODE_FILL = 2'b11).
  - PWM_W = 4.
  - function next_pattern(mode, pattern, dir).
- One sub-module: marquee_tick_gen.
  - Owns the prescaler and speed divider.
  - Inputs: clk, rst, en, clr, speed.
  - Output: step.
- The top level holds the pattern/dir registers, mode_q, and the optional PWM logic.

Test Plan:
All scenarios use N_LED = 4 and DIV_MAX = 4.
1. Reset: rst = 1 for 3 cycles, mode = 00, speed = 0, en = 1 -> led = 0001, led4_g = 0, led5_g = 1 during reset; first change to 0010 exactly 4 clocks after rst drops.
2. Rotate left, speed = 0: steps give 0001 -> 0010 -> 0100 -> 1000 -> 0001 every 4 clocks, with led4_g toggling each step. With speed = 2, steps occur every 16 clocks.
3. Bounce: sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; led5_g falls on the step that leaves 1000 and rises on the step that leaves 0001.
4. Fill: 0001 -> 0011 -> 0111 -> 1111 -> 1110 -> 1100 -> 1000 -> 0000 -> 0001 (8-step period).
5. Freeze: drop en at led = 0100 for 20 clocks -> led and led4_g hold. After en returns, the next step arrives after the remaining prescaler count, not a full period.
6. Mode switch and mid-run reset:
   - Change mode 00 -> 01 at led = 0100 -> one clock after mode_q differs, led = 0001 and led5_g = 0; then 1000 after 4 clocks.
   - A 1-cycle rst mid-run -> reset values on the next edge.
